// File: rtl/ms_slave_sink.sv
// ms_slave_sink: slave end of the ms_if master/slave link.
// Every cycle with sready high captures (addr, data) into a small FIFO. A
// rate-limited drain engine retires entries into a 2**ADDR_W x DATA_W
// register bank, and the bank can be read combinationally through rd_addr.
// Optional build macro MS_SLAVE_SEQ_CHECK_EN adds a sticky sequence checker
// on seq_err. Without the macro, seq_err is tied low.
module ms_slave_sink #(
  parameter int unsigned ADDR_W         = 2,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned DRAIN_INTERVAL = 3
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        data,
  output logic                     sready,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     seq_err
);

  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = (DRAIN_INTERVAL > 1) ? $clog2(DRAIN_INTERVAL) : 1;
  localparam int unsigned NBANK = 2 ** ADDR_W;

  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW:0]       count;
  logic [PW:0]       count_next;
  logic [CW-1:0]     drain_cnt;
  logic              push;
  logic              pop;
  logic              drain_tick;

  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [DATA_W-1:0] bank      [NBANK];

  // A push is any edge where the registered sready is high; a pop needs the
  // drain slot and a non-empty FIFO at cycle start, so an entry pushed into
  // an empty FIFO is never retired on the same edge.
  always_comb begin
    push       = sready;
    drain_tick = (drain_cnt == CW'(DRAIN_INTERVAL - 1));
    pop        = drain_tick && (count != '0);
    count_next = count + (PW+1)'(push) - (PW+1)'(pop);
  end

  // Control state: occupancy, pointers, drain counter and registered ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count     <= '0;
      head      <= '0;
      tail      <= '0;
      drain_cnt <= '0;
      sready    <= 1'b0;
    end else begin
      count     <= count_next;
      drain_cnt <= drain_tick ? '0 : drain_cnt + CW'(1);
      sready    <= (count_next < (PW+1)'(DEPTH));
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
    end
  end

  // FIFO storage; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[tail] <= addr;
      fifo_data[tail] <= data;
    end
  end

  // Register bank written by the drain engine in FIFO order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NBANK; i++) bank[i] <= '0;
    end else if (pop) begin
      bank[fifo_addr[head]] <= fifo_data[head];
    end
  end

  assign rd_data    = bank[rd_addr];
  assign fifo_level = count;

`ifdef MS_SLAVE_SEQ_CHECK_EN
  logic [ADDR_W-1:0] exp_addr;
  logic [ADDR_W-1:0] prev_addr;
  logic              err_q;

  // Sequence checker: addr must count up from 0 and data must equal the
  // previous accepted addr times four; the expected addr resyncs on every
  // push (addr+1 whether or not it matched).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_addr  <= '0;
      prev_addr <= '0;
      err_q     <= 1'b0;
    end else if (push) begin
      if ((addr != exp_addr) || (data != (DATA_W'(prev_addr) << 2))) err_q <= 1'b1;
      exp_addr  <= addr + ADDR_W'(1);
      prev_addr <= addr;
    end
  end

  assign seq_err = err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_ms_slave_sink.sv
// Directed bench for ms_slave_sink: one instance with DRAIN_INTERVAL=3 and
// one with DRAIN_INTERVAL=1, each fed by a reset-pattern master that
// advances (addr+1, data=old addr*4) whenever its push was accepted.
module tb_ms_slave_sink;

`ifdef MS_SLAVE_SEQ_CHECK_EN
  localparam int SEQ_ON = 1;
`else
  localparam int SEQ_ON = 0;
`endif

  logic       clk;
  logic       rstn;
  logic [1:0] addr, addr1, rd_addr, rd_addr1;
  logic [7:0] data, data1, rd_data, rd_data1;
  logic       sready, sready1, seq_err, seq_err1;
  logic [2:0] level, level1;

  int n_cmp = 0;
  int n_err = 0;

  int exp_lvl  [15] = '{0, 1, 1, 2, 3, 3, 4, 4, 3, 4, 4, 3, 4, 4, 3};
  int exp_rdy  [15] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
  int exp_bank [4]  = '{12, 0, 4, 8};

  ms_slave_sink #(.ADDR_W(2), .DATA_W(8), .DEPTH(4), .DRAIN_INTERVAL(3)) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .data(data), .sready(sready),
    .rd_addr(rd_addr), .rd_data(rd_data), .fifo_level(level), .seq_err(seq_err)
  );

  ms_slave_sink #(.ADDR_W(2), .DATA_W(8), .DEPTH(4), .DRAIN_INTERVAL(1)) dut1 (
    .clk(clk), .rstn(rstn), .addr(addr1), .data(data1), .sready(sready1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .fifo_level(level1), .seq_err(seq_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; each master advances if its sready was high going into the edge.
  task automatic tick();
    logic r0, r1;
    r0 = sready;
    r1 = sready1;
    @(posedge clk);
    #1;
    if (r0) begin
      data = {4'b0, addr, 2'b00};
      addr = addr + 2'd1;
    end
    if (r1) begin
      data1 = {4'b0, addr1, 2'b00};
      addr1 = addr1 + 2'd1;
    end
  endtask

  task automatic master_reset();
    addr  = '0;
    data  = '0;
    addr1 = '0;
    data1 = '0;
  endtask

  initial begin
    rstn     = 1'b0;
    rd_addr  = '0;
    rd_addr1 = '0;
    master_reset();

    // Reset state
    @(posedge clk);
    #1;
    check("rst_sready", sready, 0);
    check("rst_level", level, 0);
    check("rst_seq_err", seq_err, 0);
    for (int j = 0; j < 4; j++) begin
      rd_addr = 2'(j);
      #1;
      check($sformatf("rst_bank%0d", j), rd_data, 0);
    end
    @(posedge clk);
    #1;
    rstn    = 1'b1;
    rd_addr = '0;

    // Continuous master: level climbs to 4, ready drops, drains every 3 cycles
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("lvl_c%0d", i + 1), level, exp_lvl[i]);
      check($sformatf("rdy_c%0d", i + 1), sready, exp_rdy[i]);
      check($sformatf("lvl1_c%0d", i + 1), level1, (i == 0) ? 0 : 1);
      check($sformatf("rdy1_c%0d", i + 1), sready1, 1);
      if (i == 13) check("bank0_before_write", rd_data, 0);
      if (i == 14) check("bank0_after_write", rd_data, 12);
    end
    check("seq_err_clean", seq_err, 0);
    check("seq_err1_clean", seq_err1, 0);

    // Bank contents after the pattern has drained, both drain rates
    for (int j = 0; j < 4; j++) begin
      rd_addr  = 2'(j);
      rd_addr1 = 2'(j);
      #1;
      check($sformatf("bank%0d", j), rd_data, exp_bank[j]);
      check($sformatf("bank1_%0d", j), rd_data1, exp_bank[j]);
    end

    // Mid-stream asynchronous reset with three entries buffered
    check("pre_rst_level", level, 3);
    rd_addr = '0;
    rstn    = 1'b0;
    #1;
    check("mid_rst_sready", sready, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_level1", level1, 0);
    check("mid_rst_bank0", rd_data, 0);
    for (int j = 1; j < 4; j++) begin
      rd_addr = 2'(j);
      #1;
      check($sformatf("mid_rst_bank%0d", j), rd_data, 0);
    end
    master_reset();
    rd_addr = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    check("resume_sready", sready, 1);
    check("resume_level0", level, 0);
    tick();
    check("resume_level1", level, 1);
    tick();
    check("resume_bank0", rd_data, 0);
    check("resume_seq_err", seq_err, 0);

    // Out-of-sequence first push on the main instance
    rstn = 1'b0;
    master_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    addr = 2'd2;
    data = 8'd0;
    tick();
    check("seq_err_set", seq_err, SEQ_ON);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("seq_err_sticky%0d", i), seq_err, SEQ_ON);
      check($sformatf("seq_err1_clear%0d", i), seq_err1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
